// File: rtl/axilwb_arb_pkg.sv
// axilwb_arb_pkg: shared grant-state and owner types for the AXI-lite/Wishbone read/write arbiter.
package axilwb_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_RD, GRANT_WR} state_t;
  typedef enum logic {OWN_RD, OWN_WR} owner_t;
  localparam owner_t LAST_OWNER_RST = OWN_WR;
endpackage

// File: rtl/axilwb_arb_grant.sv
// axilwb_arb_grant: non-preemptive grant FSM and last_owner register.
// Define AXILWB_ARB_ROUND_ROBIN_EN to alternate simultaneous requests; otherwise write always wins.
module axilwb_arb_grant
  import axilwb_arb_pkg::*;
(
  input  logic   i_clk,
  input  logic   w_reset,
  input  logic   i_rd_cyc,
  input  logic   i_wr_cyc,
  output state_t o_state
);
  state_t state_q, state_d;
  owner_t last_owner_q, last_owner_d;
  logic   pick_rd;
`ifdef AXILWB_ARB_ROUND_ROBIN_EN
  assign pick_rd = last_owner_q == OWN_WR;
`else
  assign pick_rd = 1'b0;
`endif
  always_ff @(posedge i_clk) begin
    if (w_reset) begin
      state_q      <= IDLE;
      last_owner_q <= LAST_OWNER_RST;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end
  // An owner keeps the bus until its own cyc drops; only then may the other side take it.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:     state_d = (i_rd_cyc && i_wr_cyc) ? (pick_rd ? GRANT_RD : GRANT_WR) :
                          i_rd_cyc ? GRANT_RD : i_wr_cyc ? GRANT_WR : IDLE;
      GRANT_RD: state_d = i_rd_cyc ? GRANT_RD : i_wr_cyc ? GRANT_WR : IDLE;
      GRANT_WR: state_d = i_wr_cyc ? GRANT_WR : i_rd_cyc ? GRANT_RD : IDLE;
      default:  state_d = IDLE;
    endcase
    last_owner_d = state_d == GRANT_RD ? OWN_RD : state_d == GRANT_WR ? OWN_WR : last_owner_q;
  end
  always_comb o_state = state_q;
endmodule

// File: rtl/axilwb_rdwr_arbiter.sv
// axilwb_rdwr_arbiter: shares one Wishbone slave between the AXI-lite read and write bridges.
// Optional macro AXILWB_ARB_ROUND_ROBIN_EN (in axilwb_arb_grant) selects round-robin tie-breaking.
module axilwb_rdwr_arbiter
  import axilwb_arb_pkg::*;
#(
  parameter int AW = 26,
  parameter int DW = 32
) (
  input  logic            i_clk,
  input  logic            w_reset,
  input  logic            i_rd_cyc,
  input  logic            i_rd_stb,
  input  logic [AW-1:0]   i_rd_addr,
  output logic            o_rd_ack,
  output logic            o_rd_stall,
  output logic            o_rd_err,
  output logic [DW-1:0]   o_rd_data,
  input  logic            i_wr_cyc,
  input  logic            i_wr_stb,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [DW-1:0]   i_wr_data,
  input  logic [DW/8-1:0] i_wr_sel,
  output logic            o_wr_ack,
  output logic            o_wr_stall,
  output logic            o_wr_err,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);
  state_t state;
  logic   rd_own, wr_own;
  axilwb_arb_grant u_grant (
    .i_clk    (i_clk),
    .w_reset  (w_reset),
    .i_rd_cyc (i_rd_cyc),
    .i_wr_cyc (i_wr_cyc),
    .o_state  (state)
  );
  assign rd_own     = state == GRANT_RD;
  assign wr_own     = state == GRANT_WR;
  assign o_wb_cyc   = rd_own ? i_rd_cyc : wr_own ? i_wr_cyc : 1'b0;
  assign o_wb_stb   = rd_own ? i_rd_cyc & i_rd_stb : wr_own ? i_wr_cyc & i_wr_stb : 1'b0;
  assign o_wb_we    = wr_own;
  assign o_wb_addr  = rd_own ? i_rd_addr : wr_own ? i_wr_addr : '0;
  assign o_wb_data  = wr_own ? i_wr_data : '0;
  assign o_wb_sel   = rd_own ? '1 : wr_own ? i_wr_sel : '0;
  // Gating with o_wb_cyc drops responses that arrive while no owner is driving a cycle.
  assign o_rd_ack   = rd_own & i_wb_ack & o_wb_cyc;
  assign o_rd_err   = rd_own & i_wb_err & o_wb_cyc;
  assign o_rd_stall = rd_own ? i_wb_stall : 1'b1;
  assign o_rd_data  = i_wb_data;
  assign o_wr_ack   = wr_own & i_wb_ack & o_wb_cyc;
  assign o_wr_err   = wr_own & i_wb_err & o_wb_cyc;
  assign o_wr_stall = wr_own ? i_wb_stall : 1'b1;
endmodule

// File: doc/axilwb_rdwr_arbiter.md
AXILWB_RDWR_ARBITER -- requirements
Module: axilwb_rdwr_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 26, meaning the word address width of all Wishbone ports.
REQ-002 The block SHALL have parameter DW, default 32, meaning the data width of all Wishbone ports.
REQ-003 The block SHALL have the port i_clk, input, width 1, meaning the system clock (all logic on its rising edge).
REQ-004 The block SHALL have the port w_reset, input, width 1, meaning the synchronous, active-high reset.
REQ-005 The block SHALL have read-master ports i_rd_cyc, i_rd_stb (1), i_rd_addr (AW), o_rd_ack, o_rd_stall, o_rd_err (1), and o_rd_data (DW), driven by the AXI-lite read bridge.
REQ-006 The block SHALL have write-master ports i_wr_cyc, i_wr_stb (1), i_wr_addr (AW), i_wr_data (DW), i_wr_sel (DW/8), o_wr_ack, o_wr_stall, and o_wr_err (1), driven by the AXI-lite write bridge.
REQ-007 The block SHALL have slave ports o_wb_cyc, o_wb_stb, o_wb_we (1), o_wb_addr (AW), o_wb_data (DW), o_wb_sel (DW/8), i_wb_ack, i_wb_stall, i_wb_err (1), and i_wb_data (DW).

Function
REQ-008 The grant FSM SHALL have the states IDLE, GRANT_RD and GRANT_WR, held in a registered state variable.
REQ-009 In IDLE, the FSM SHALL behave as follows:
- only i_rd_cyc high -> GRANT_RD next cycle;
- only i_wr_cyc high -> GRANT_WR next cycle;
- both high -> arbitration per REQ-017/018;
- neither high -> stay in IDLE.
REQ-010 In GRANT_x, the FSM SHALL behave as follows:
- owner cyc high -> stay in GRANT_x;
- owner cyc low and other cyc high -> GRANT_other next cycle;
- owner cyc low and other cyc low -> IDLE.
REQ-011 A grant SHALL never change while the owner's cyc is high, and SHALL never be pre-empted or time-sliced.
REQ-012 The slave outputs SHALL be combinational from the state register and the owner's inputs:
- o_wb_cyc = owner cyc;
- o_wb_stb = owner cyc & owner stb;
- o_wb_we = 1 in GRANT_WR, 0 otherwise;
- addr/data/sel are muxed from the owner;
- in GRANT_RD, o_wb_sel is all ones and o_wb_data is zero.
REQ-013 In IDLE, o_wb_cyc, o_wb_stb and o_wb_we SHALL be 0, and o_wb_addr, o_wb_data and o_wb_sel SHALL be 0.
REQ-014 The owner SHALL receive ack = i_wb_ack & o_wb_cyc, err = i_wb_err & o_wb_cyc, and stall = i_wb_stall.
REQ-015 The non-owner SHALL receive stall = 1, ack = 0 and err = 0 in every cycle.
REQ-016 o_rd_data SHALL equal i_wb_data with zero added latency.
REQ-017 Simultaneous requests in IDLE, and the handover decision out of GRANT_x, SHALL be resolved by the priority rule of the Configuration section.
REQ-018 An ack or err arriving in IDLE, or while the owner's cyc is low, SHALL be discarded and forwarded to neither master.
REQ-019 The latency from a master raising cyc in IDLE to o_wb_cyc high SHALL be exactly 1 cycle.
REQ-020 The bus SHALL have exactly 1 idle cycle (o_wb_cyc = 0) between owners on a handover.
REQ-021 The block SHALL keep a registered last_owner bit, updated on every entry to GRANT_RD or GRANT_WR.

Reset
REQ-022 Reset SHALL force state = IDLE and last_owner = WR on the next edge, including mid-transaction.
REQ-023 After reset, o_wb_cyc and o_wb_stb SHALL be 0, o_rd_stall and o_wr_stall SHALL be 1, and all acks and errs SHALL be 0.
REQ-024 The block SHALL not itself generate acks or errs for a transaction aborted by reset; the bridges reset on the same w_reset.

Configuration
REQ-025 When macro AXILWB_ARB_ROUND_ROBIN_EN is defined, a simultaneous request SHALL be granted to the master not equal to last_owner, so that the read master wins first after reset.
REQ-026 When AXILWB_ARB_ROUND_ROBIN_EN is undefined, the write master SHALL always win a simultaneous request, and last_owner SHALL be retained but unused.

Structure
REQ-027 Package axilwb_arb_pkg SHALL hold the state enum (IDLE, GRANT_RD, GRANT_WR), the owner enum (OWN_RD, OWN_WR), and the localparam for the reset value of last_owner.
REQ-028 Sub-module axilwb_arb_grant SHALL contain the FSM and the last_owner register, with inputs the two cyc signals and output the state.
REQ-029 The top level SHALL contain only the combinational muxing and response routing.

Verification
REQ-030 Reset, then i_rd_cyc=i_rd_stb=1 with addr 0x10 at cycle 0 -> o_wb_cyc=o_wb_stb=1, o_wb_we=0, o_wb_addr=0x10 at cycle 1; i_wb_ack=1 with i_wb_data=0xDEADBEEF -> o_rd_ack=1 and o_rd_data=0xDEADBEEF in the same cycle.
REQ-031 Write master holds cyc through 3 stalled cycles with i_wb_stall=1 while the read master raises cyc -> o_rd_stall=1 throughout and GRANT_WR is held; write cyc drop -> GRANT_RD one cycle later with one o_wb_cyc=0 gap.
REQ-032 Both cyc rise together in IDLE after reset -> read is granted with the macro defined and write without it; repeating after release alternates only with the macro defined.
REQ-033 i_wb_err=1 during GRANT_WR -> o_wr_err=1, o_rd_err=0; a stray i_wb_ack in IDLE -> o_rd_ack=o_wr_ack=0.
REQ-034 w_reset pulsed during GRANT_RD with a stalled stb -> IDLE and o_wb_cyc=0 next cycle, and both stalls = 1.
